// File: rtl/adc_pkg.sv
// adc_pkg: shared states, config bit positions and sizes for the ADC serial responder
package adc_pkg;
    typedef enum logic [2:0] {IDLE, CONV, READY, SHIFT, DONE} state_e;
    localparam int CFG_SD  = 5;
    localparam int CFG_OS  = 4;
    localparam int CFG_S1  = 3;
    localparam int CFG_S0  = 2;
    localparam int CFG_UNI = 1;
    localparam int CFG_SLP = 0;
    localparam int ADC_BITS = 12;
    localparam int CFG_BITS = 6;
    localparam logic [CFG_BITS-1:0] CFG_RST = 6'b100000;
endpackage

// File: rtl/adc_spi_responder_pin_sync_edge.sv
// pin_sync_edge: two-flop synchronizer with a history flop producing rise/fall strobes
module pin_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1_q, s2_q, prev_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= pin;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end
    assign level = s2_q;
    assign rise  = s2_q & ~prev_q;
    assign fall  = ~s2_q & prev_q;
endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: LTC2308-style converter stand-in serving ch_data samples over the ADC serial pins
module adc_spi_responder
    import adc_pkg::*;
#(
    parameter int T_CONV = 80,
    parameter int NCH    = 8
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    ADC_CONVST,
    input  logic                    ADC_SCLK,
    input  logic                    ADC_DIN,
    output logic                    ADC_DOUT,
    input  logic [NCH*ADC_BITS-1:0] ch_data,
    output logic [CFG_BITS-1:0]     cfg,
    output logic                    cfg_valid,
    output logic                    busy,
    output logic                    proto_err
);
    localparam int TW = $clog2(T_CONV) + 1;
    logic cv_lvl, cv_rise, cv_fall, sc_lvl, sc_rise, sc_fall, din, din_rise, din_fall;
    pin_sync_edge u_cv  (.clk(CLOCK_50), .rst(reset), .pin(ADC_CONVST), .level(cv_lvl), .rise(cv_rise), .fall(cv_fall));
    pin_sync_edge u_sc  (.clk(CLOCK_50), .rst(reset), .pin(ADC_SCLK), .level(sc_lvl), .rise(sc_rise), .fall(sc_fall));
    pin_sync_edge u_din (.clk(CLOCK_50), .rst(reset), .pin(ADC_DIN), .level(din), .rise(din_rise), .fall(din_fall));
    logic unused_pins;
    assign unused_pins = ^{cv_lvl, cv_fall, sc_lvl, din_rise, din_fall};
    state_e                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [2:0]            ch_q, ch_d;
    logic                  sd_q, sd_d;
    logic [ADC_BITS-1:0]   sh_q, sh_d, sample;
    logic [3:0]            rcnt_q, rcnt_d, fcnt_q, fcnt_d;
    logic [CFG_BITS-1:0]   csh_q, csh_d, cfg_q, cfg_d;
    logic                  cfg_valid_q, cfg_valid_d, perr_q, perr_d;
    assign sample = ch_data[ch_q*ADC_BITS +: ADC_BITS];
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        ch_d        = ch_q;
        sd_d        = sd_q;
        sh_d        = sh_q;
        rcnt_d      = rcnt_q;
        fcnt_d      = fcnt_q;
        csh_d       = csh_q;
        cfg_d       = cfg_q;
        cfg_valid_d = 1'b0;
        perr_d      = perr_q;
        // CONVST outranks any SCLK strobe in the same cycle
        if (cv_rise && state_q != CONV) begin
            if ((state_q == READY || state_q == SHIFT) && rcnt_q < 4'(CFG_BITS))
                perr_d = 1'b1;
            state_d = CONV;
            timer_d = TW'(T_CONV - 1);
            ch_d    = {cfg_q[CFG_S1], cfg_q[CFG_S0], cfg_q[CFG_OS]};
            sd_d    = cfg_q[CFG_SD];
            rcnt_d  = '0;
            fcnt_d  = '0;
            csh_d   = '0;
        end else begin
            if (cv_rise)
                perr_d = 1'b1;
            case (state_q)
                CONV: begin
                    if (sc_rise || sc_fall)
                        perr_d = 1'b1;
                    if (timer_q == '0) begin
                        state_d = READY;
                        sh_d    = sd_q ? sample : '0;
                        if (!sd_q)
                            perr_d = 1'b1;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                READY, SHIFT: begin
                    if (sc_rise) begin
                        state_d = SHIFT;
                        csh_d   = {csh_q[CFG_BITS-2:0], din};
                        rcnt_d  = rcnt_q + 4'd1;
                        if (rcnt_q == 4'(CFG_BITS - 1)) begin
                            cfg_d       = csh_d;
                            cfg_valid_d = 1'b1;
                        end
                    end
                    if (sc_fall && state_q == SHIFT) begin
                        sh_d   = sh_q << 1;
                        fcnt_d = fcnt_q + 4'd1;
                        if (fcnt_q == 4'(ADC_BITS - 1))
                            state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            ch_q        <= '0;
            sd_q        <= 1'b1;
            sh_q        <= '0;
            rcnt_q      <= '0;
            fcnt_q      <= '0;
            csh_q       <= '0;
            cfg_q       <= CFG_RST;
            cfg_valid_q <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ch_q        <= ch_d;
            sd_q        <= sd_d;
            sh_q        <= sh_d;
            rcnt_q      <= rcnt_d;
            fcnt_q      <= fcnt_d;
            csh_q       <= csh_d;
            cfg_q       <= cfg_d;
            cfg_valid_q <= cfg_valid_d;
            perr_q      <= perr_d;
        end
    end
    assign ADC_DOUT  = (state_q == READY || state_q == SHIFT) & sh_q[ADC_BITS-1];
    assign busy      = state_q == CONV;
    assign cfg       = cfg_q;
    assign cfg_valid = cfg_valid_q;
    assign proto_err = perr_q;
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: directed checks of conversion timing, readout, config capture and error flags
module tb_adc_spi_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        convst = 1'b0;
    logic        sclk = 1'b0;
    logic        din = 1'b0;
    logic        dout;
    logic [95:0] ch_data = '0;
    logic [5:0]  cfg;
    logic        cfg_valid, busy, proto_err;
    int          vecs = 0;
    int          fails = 0;
    int          vcnt = 0;
    int          hi;
    logic [15:0] rd;

    adc_spi_responder #(.T_CONV(80), .NCH(8)) dut (
        .CLOCK_50(clk), .reset(reset), .ADC_CONVST(convst), .ADC_SCLK(sclk), .ADC_DIN(din),
        .ADC_DOUT(dout), .ch_data(ch_data), .cfg(cfg), .cfg_valid(cfg_valid), .busy(busy),
        .proto_err(proto_err)
    );

    always #10 clk = ~clk;
    always @(negedge clk) if (cfg_valid) vcnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        cycles(2);
    endtask

    task automatic conv(output int h);
        h = 0;
        convst = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 4) convst = 1'b0;
            if (busy) h++;
            else if (h > 0) break;
        end
        convst = 1'b0;
    endtask

    task automatic frame(input int n, input logic [5:0] w, output logic [15:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            din = (i < 6) ? w[5-i] : 1'b0;
            cycles(6);
            r = {r[14:0], dout};
            sclk = 1'b1;
            cycles(6);
            sclk = 1'b0;
        end
        din = 1'b0;
        cycles(6);
    endtask

    initial begin
        ch_data[11:0]  = 12'hA5C;
        ch_data[23:12] = 12'h3F0;
        do_reset();
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_cfg", 32'(cfg), 32'h20);
        check("rst_cfg_valid", 32'(cfg_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_perr", 32'(proto_err), 32'h0);

        // 1: basic conversion and readout of CH0
        conv(hi);
        check("t1_busy_len", 32'(hi), 32'd80);
        frame(12, 6'b100000, rd);
        check("t1_data", 32'(rd[11:0]), 32'hA5C);
        check("t1_dout_done", 32'(dout), 32'h0);
        check("t1_valid_cnt", 32'(vcnt), 32'd1);

        // 2: select CH1, applies on the following conversion
        conv(hi);
        frame(12, 6'b110000, rd);
        check("t2_f1_data", 32'(rd[11:0]), 32'hA5C);
        check("t2_valid_cnt", 32'(vcnt), 32'd2);
        check("t2_cfg", 32'(cfg), 32'h30);
        conv(hi);
        frame(12, 6'b110000, rd);
        check("t2_f2_data", 32'(rd[11:0]), 32'h3F0);
        check("t2_perr", 32'(proto_err), 32'h0);

        // 3: differential request yields zero and flags an error
        conv(hi);
        frame(12, 6'b011000, rd);
        check("t3_f1_data", 32'(rd[11:0]), 32'h3F0);
        check("t3_cfg", 32'(cfg), 32'h18);
        check("t3_perr_pre", 32'(proto_err), 32'h0);
        conv(hi);
        check("t3_perr", 32'(proto_err), 32'h1);
        frame(12, 6'b100000, rd);
        check("t3_data", 32'(rd[11:0]), 32'h000);

        // 4: abort after 3 SCLK cycles
        do_reset();
        conv(hi);
        frame(3, 6'b110000, rd);
        check("t4_partial", 32'(rd[2:0]), 32'h5);
        conv(hi);
        check("t4_busy_len", 32'(hi), 32'd80);
        check("t4_cfg", 32'(cfg), 32'h20);
        check("t4_perr", 32'(proto_err), 32'h1);
        frame(12, 6'b100000, rd);
        check("t4_data", 32'(rd[11:0]), 32'hA5C);

        // 5: SCLK during CONV; sample taken at end of conversion
        do_reset();
        convst = 1'b1;
        cycles(4);
        convst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sclk = 1'b1;
            cycles(6);
            sclk = 1'b0;
            cycles(6);
        end
        ch_data[11:0] = 12'h5A5;
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("t5_conv_end", 32'(busy), 32'h0);
        check("t5_perr", 32'(proto_err), 32'h1);
        frame(12, 6'b100000, rd);
        check("t5_data", 32'(rd[11:0]), 32'h5A5);
        ch_data[11:0] = 12'hA5C;
        conv(hi);
        frame(7, 6'b110000, rd);
        check("t5_cfg_mid", 32'(cfg), 32'h30);
        reset = 1'b1;
        cycles(1);
        check("t5_rst_dout", 32'(dout), 32'h0);
        check("t5_rst_cfg", 32'(cfg), 32'h20);
        check("t5_rst_valid", 32'(cfg_valid), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_perr", 32'(proto_err), 32'h0);
        reset = 1'b0;
        cycles(4);

        // 6: 14 SCLK cycles, trailing bits read 0
        conv(hi);
        frame(14, 6'b100000, rd);
        check("t6_data", 32'(rd[13:0]), 32'h2970);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_dout", 32'(dout), 32'h0);
        check("t6_perr", 32'(proto_err), 32'h0);
        conv(hi);
        check("t6_restart", 32'(hi), 32'd80);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
